// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, stage-count helper and result flag type for the ALU adders
package alu_pkg;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;
   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } add_flags_t;
   function automatic int stages_f(input int width, input int chunk);
      return width / chunk;
   endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bus of the pipelined adder
interface pipelined_adder_if
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sub;
   logic             in_cin;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             out_zero;
   modport master (
      output in_valid, in_sub, in_cin, in1, in2, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
   modport slave (
      input  in_valid, in_sub, in_cin, in1, in2, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
   );
endinterface

// File: rtl/adder_chunk.sv
// adder_chunk: combinational N-bit carry-lookahead slice
module adder_chunk
   import alu_pkg::*;
#(
   parameter int N = DEF_CHUNK
) (
   input  logic         cin,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         cout,
   output logic [N-1:0] sum
);
   logic [N-1:0] g, p;
   logic [N:0]   c;
   logic         t;
   assign g = a & b;
   assign p = a ^ b;
   // each carry is expanded from cin independently rather than taken from its neighbour
   always_comb begin
      c = '0;
      t = 1'b0;
      for (int i = 0; i <= N; i++) begin
         t = cin;
         for (int j = 0; j < i; j++) t = g[j] | (p[j] & t);
         c[i] = t;
      end
   end
   assign sum  = p ^ c[N-1:0];
   assign cout = c[N];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub, one CHUNK slice per stage, valid/ready with full backpressure
// Define PIPELINED_ADDER_SAT_EN to saturate the result on signed overflow.
module pipelined_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_adder_if.slave  bus
);
   localparam int STAGES = stages_f(WIDTH, CHUNK);
   logic adv;
   assign adv          = bus.out_ready | ~bus.out_valid;
   assign bus.in_ready = adv;
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * CHUNK;
      localparam int HI = LO + CHUNK;
      logic [WIDTH-1:LO] a_i, b_i;
      logic [HI-1:0]     s_n;
      logic [CHUNK-1:0]  sl;
      logic              c_i, v_i, co;
      if (k == 0) begin : g_first
         assign a_i = bus.in1;
         assign b_i = bus.in_sub ? ~bus.in2 : bus.in2;
         assign c_i = bus.in_sub | bus.in_cin;
         assign v_i = bus.in_valid;
         assign s_n = sl;
      end else begin : g_next
         assign a_i = g_st[k-1].g_reg.a_q;
         assign b_i = g_st[k-1].g_reg.b_q;
         assign c_i = g_st[k-1].g_reg.c_q;
         assign v_i = g_st[k-1].g_reg.v_q;
         assign s_n = {sl, g_st[k-1].g_reg.s_q};
      end
      adder_chunk #(.N(CHUNK)) u_chunk (
         .cin  (c_i),
         .a    (a_i[LO +: CHUNK]),
         .b    (b_i[LO +: CHUNK]),
         .cout (co),
         .sum  (sl)
      );
      if (k < STAGES - 1) begin : g_reg
         // only the not-yet-added operand slices travel on; finished sum slices accumulate
         logic [WIDTH-1:HI] a_q, b_q;
         logic [HI-1:0]     s_q;
         logic              c_q, v_q;
         always_ff @(posedge clk)
            if (!rst_n) v_q <= 1'b0;
            else if (adv) begin
               v_q <= v_i;
               c_q <= co;
               a_q <= a_i[WIDTH-1:HI];
               b_q <= b_i[WIDTH-1:HI];
               s_q <= s_n;
            end
      end else begin : g_out
         logic             ovf;
         logic [WIDTH-1:0] res;
         add_flags_t       flags_q;
         assign ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) & (s_n[WIDTH-1] != a_i[WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
         assign res = ovf ? {a_i[WIDTH-1], {(WIDTH-1){~a_i[WIDTH-1]}}} : s_n;
`else
         assign res = s_n;
`endif
         always_ff @(posedge clk)
            if (!rst_n) begin
               bus.out_valid <= 1'b0;
               bus.out_sum   <= '0;
               flags_q       <= '0;
            end else if (adv) begin
               bus.out_valid <= v_i;
               bus.out_sum   <= res;
               flags_q       <= '{cout: co, ovf: ovf, zero: ~|res};
            end
         assign bus.out_cout = flags_q.cout;
         assign bus.out_ovf  = flags_q.ovf;
         assign bus.out_zero = flags_q.zero;
      end
   end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors with hand-computed results for the 32/8 pipelined adder
module tb_pipelined_adder;
   import alu_pkg::*;
   localparam int W = 32;
   typedef struct {
      logic         sub;
      logic         cin;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   vec_t vec[16];
   logic [63:0] rdy_pat = 64'hB3A5_6C9E_F0D1_2B47;
   always #5 clk = ~clk;
   pipelined_adder_if #(.WIDTH(W)) bus ();
   pipelined_adder #(.WIDTH(W), .CHUNK(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic sub, input logic cin, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.in_sub   = sub;
      bus.in_cin   = cin;
      bus.in1      = a;
      bus.in2      = b;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask
   task automatic result(input string tag, input logic [W-1:0] s, input logic co, input logic ov, input logic z);
      int n = 1;
      while (!bus.out_valid && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, W'(n), W'(4));
      chk({tag, "_sum"}, bus.out_sum, s);
      chk({tag, "_cout"}, W'(bus.out_cout), W'(co));
      chk({tag, "_ovf"}, W'(bus.out_ovf), W'(ov));
      chk({tag, "_zero"}, W'(bus.out_zero), W'(z));
   endtask
   initial begin
      int idx, oidx;
      logic stall;
      logic [W-1:0] held;
      vec[0]  = '{1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
      vec[1]  = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100};
      vec[2]  = '{1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000};
      vec[3]  = '{1'b0, 1'b0, 32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000};
      vec[4]  = '{1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
      vec[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F};
      vec[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      vec[7]  = '{1'b0, 1'b1, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0100};
      vec[8]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000};
      vec[9]  = '{1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF};
      vec[10] = '{1'b0, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000};
      vec[11] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0800, 32'h0000_0800};
      vec[12] = '{1'b0, 1'b0, 32'h4000_0000, 32'h3FFF_FFFF, 32'h7FFF_FFFF};
      vec[13] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vec[14] = '{1'b0, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hFFFF_FFFF};
      vec[15] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF};
      bus.in_valid  = 1'b1;
      bus.in_sub    = 1'b0;
      bus.in_cin    = 1'b1;
      bus.in1       = 32'h1234_5678;
      bus.in2       = 32'h0000_0001;
      bus.out_ready = 1'b1;
      // reset while a beat is offered
      repeat (3) step();
      chk("rst_valid", W'(bus.out_valid), W'(0));
      chk("rst_sum", bus.out_sum, '0);
      chk("rst_ready", W'(bus.in_ready), W'(1));
      chk("rst_flags", W'({bus.out_cout, bus.out_ovf, bus.out_zero}), W'(0));
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("no_spurious", W'(bus.out_valid), W'(0));
      end
      send(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      result("ripple", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      send(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007);
      result("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
`ifdef PIPELINED_ADDER_SAT_EN
      result("sub_ovf", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
      result("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
      send(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
`ifdef PIPELINED_ADDER_SAT_EN
      result("add_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
      result("add_ovf", 32'h8000_0001, 1'b0, 1'b1, 1'b0);
`endif
      step();
      chk("drain1", W'(bus.out_valid), W'(0));
      // back-to-back stream with a fixed irregular out_ready pattern
      idx   = 0;
      oidx  = 0;
      stall = 1'b0;
      held  = '0;
      for (int cyc = 0; cyc < 300 && oidx < 16; cyc++) begin
         bus.out_ready = rdy_pat[cyc % 64];
         bus.in_valid  = (idx < 16);
         if (idx < 16) begin
            bus.in_sub = vec[idx].sub;
            bus.in_cin = vec[idx].cin;
            bus.in1    = vec[idx].a;
            bus.in2    = vec[idx].b;
         end
         #1;
         if (stall) begin
            chk("hold_valid", W'(bus.out_valid), W'(1));
            chk("hold_sum", bus.out_sum, held);
         end
         stall = bus.out_valid & ~bus.out_ready;
         held  = bus.out_sum;
         if (bus.out_valid && bus.out_ready) begin
            chk($sformatf("strm%0d", oidx), bus.out_sum, vec[oidx].sum);
            oidx++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("strm_count", W'(oidx), W'(16));
      chk("strm_accepted", W'(idx), W'(16));
      repeat (5) begin
         chk("strm_no_dup", W'(bus.out_valid), W'(0));
         step();
      end
      // reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         bus.in_sub   = 1'b0;
         bus.in_cin   = 1'b0;
         bus.in1      = W'(i + 1);
         bus.in2      = 32'h0000_0010;
         bus.in_valid = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      step();
      chk("flush_valid", W'(bus.out_valid), W'(0));
      chk("flush_sum", bus.out_sum, '0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("flush_gone", W'(bus.out_valid), W'(0));
      end
      send(1'b0, 1'b0, 32'h0000_0020, 32'h0000_0022);
      result("after_flush", 32'h0000_0042, 1'b0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
